// File: rtl/count_n_ud_if.sv
// Control and status bundle of the count_n_ud up/down counter.
// The master drives the controls; the counter (slave) returns count, TC and WRAP.
interface count_n_ud_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             load;
  logic             up;
  logic             sat;
  logic [WIDTH-1:0] MAX;
  logic [WIDTH-1:0] CNT_In;
  logic [WIDTH-1:0] CNT;
  logic             TC;
  logic             WRAP;

  modport master (
    output EN, load, up, sat, MAX, CNT_In,
    input  CNT, TC, WRAP
  );

  modport slave (
    input  EN, load, up, sat, MAX, CNT_In,
    output CNT, TC, WRAP
  );
endinterface

// File: rtl/count_n_ud.sv
// WIDTH-bit up/down counter with programmable inclusive bound MAX,
// wrap/saturate mode, combinational terminal count and registered wrap pulse.
module count_n_ud #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        res,
  count_n_ud_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic             w_at_top;
  logic             w_at_zero;

  // A count above MAX (MAX lowered at run time) is treated as at the top bound.
  assign w_at_top  = (r_cnt >= bus.MAX);
  assign w_at_zero = (r_cnt == ZERO);

  // Next-state selection: load, then hold, then the directed step.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    if (bus.load) begin
      w_cnt_nxt = (bus.CNT_In > bus.MAX) ? bus.MAX : bus.CNT_In;
    end else if (!bus.EN) begin
      w_cnt_nxt = r_cnt;
    end else if (bus.up) begin
      if (!w_at_top) begin
        w_cnt_nxt = r_cnt + ONE;
      end else if (bus.sat) begin
        w_cnt_nxt = bus.MAX;
      end else begin
        w_cnt_nxt  = ZERO;
        w_wrap_nxt = 1'b1;
      end
    end else begin
      if (r_cnt > bus.MAX) begin
        w_cnt_nxt = bus.MAX;
      end else if (!w_at_zero) begin
        w_cnt_nxt = r_cnt - ONE;
      end else if (bus.sat) begin
        w_cnt_nxt = ZERO;
      end else begin
        w_cnt_nxt  = bus.MAX;
        w_wrap_nxt = 1'b1;
      end
    end
  end

  // Count and wrap-pulse registers with asynchronous clear.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_cnt  <= ZERO;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bus.CNT  = r_cnt;
  assign bus.WRAP = r_wrap;
  assign bus.TC   = bus.EN & ~bus.load & ((bus.up & w_at_top) | (~bus.up & w_at_zero));

endmodule

// File: tb/tb_count_n_ud.sv
// Bench for count_n_ud: three widths (8, 4, 16) driven in lockstep from shared
// stimulus, checked against a directed table and an arithmetic reference model.
module tb_count_n_ud;

  logic        clk;
  logic        res;
  logic        en, ld, up, sat;
  logic [31:0] mx, ci;

  int n_vec = 0;
  int n_err = 0;

  int     W [3] = '{8, 4, 16};
  longint m_cnt [3];
  bit     m_wrap [3];

  count_n_ud_if #(.WIDTH(8))  if8 ();
  count_n_ud_if #(.WIDTH(4))  if4 ();
  count_n_ud_if #(.WIDTH(16)) if16 ();

  assign if8.EN  = en;  assign if8.load  = ld;  assign if8.up  = up;  assign if8.sat  = sat;
  assign if4.EN  = en;  assign if4.load  = ld;  assign if4.up  = up;  assign if4.sat  = sat;
  assign if16.EN = en;  assign if16.load = ld;  assign if16.up = up;  assign if16.sat = sat;
  assign if8.MAX  = mx[7:0];  assign if8.CNT_In  = ci[7:0];
  assign if4.MAX  = mx[3:0];  assign if4.CNT_In  = ci[3:0];
  assign if16.MAX = mx[15:0]; assign if16.CNT_In = ci[15:0];

  count_n_ud #(.WIDTH(8))  dut8  (.clk(clk), .res(res), .bus(if8));
  count_n_ud #(.WIDTH(4))  dut4  (.clk(clk), .res(res), .bus(if4));
  count_n_ud #(.WIDTH(16)) dut16 (.clk(clk), .res(res), .bus(if16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         en, ld, up, sat;
    logic [7:0] mx, ci, cnt;
    bit         wrap, tc;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] d_cnt(input int i);
    case (i)
      0:       return 64'(if8.CNT);
      1:       return 64'(if4.CNT);
      default: return 64'(if16.CNT);
    endcase
  endfunction

  function automatic logic [63:0] d_wrap(input int i);
    case (i)
      0:       return 64'(if8.WRAP);
      1:       return 64'(if4.WRAP);
      default: return 64'(if16.WRAP);
    endcase
  endfunction

  function automatic logic [63:0] d_tc(input int i);
    case (i)
      0:       return 64'(if8.TC);
      1:       return 64'(if4.TC);
      default: return 64'(if16.TC);
    endcase
  endfunction

  // Reference: range is 0..MAX (MAX seen truncated to w bits); step, clamp or wrap.
  function automatic void model(input int w, input longint c, output longint nc,
                                output bit nw, output bit tc);
    longint mask = (64'd1 << w) - 1;
    longint m = longint'(mx) & mask;
    longint v = longint'(ci) & mask;
    nc = c;
    nw = 1'b0;
    tc = en && !ld && ((up && c >= m) || (!up && c == 0));
    if (ld)               nc = (v < m) ? v : m;
    else if (!en)         nc = c;
    else if (up) begin
      if (c < m)          nc = c + 1;
      else if (sat)       nc = m;
      else begin          nc = 0; nw = 1'b1; end
    end else begin
      if (c > m)          nc = m;
      else if (c > 0)     nc = c - 1;
      else if (sat)       nc = 0;
      else begin          nc = m; nw = 1'b1; end
    end
  endfunction

  task automatic set_in(input bit e, input bit l, input bit u, input bit s,
                        input logic [31:0] m, input logic [31:0] c);
    en = e; ld = l; up = u; sat = s; mx = m; ci = c;
  endtask

  task automatic apply(input string nm);
    longint nc [3];
    bit     nw [3];
    bit     tc [3];
    #1;
    for (int i = 0; i < 3; i++) begin
      model(W[i], m_cnt[i], nc[i], nw[i], tc[i]);
      chk($sformatf("%s.tc.w%0d", nm, W[i]), d_tc(i), 64'(tc[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]  = nc[i];
      m_wrap[i] = nw[i];
      chk($sformatf("%s.cnt.w%0d", nm, W[i]), d_cnt(i), 64'(m_cnt[i]));
      chk($sformatf("%s.wrap.w%0d", nm, W[i]), d_wrap(i), 64'(m_wrap[i]));
    end
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock.
  task automatic do_reset(input string nm);
    #2;
    res = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]  = 0;
      m_wrap[i] = 1'b0;
      chk($sformatf("%s.async_cnt.w%0d", nm, W[i]), d_cnt(i), 64'd0);
      chk($sformatf("%s.async_wrap.w%0d", nm, W[i]), d_wrap(i), 64'd0);
    end
    @(posedge clk);
    #1;
    chk({nm, ".held_cnt"}, d_cnt(0), 64'd0);
    #2;
    res = 1'b1;
  endtask

  function automatic void add(input bit e, input bit l, input bit u, input bit s,
                              input int m, input int c, input int q,
                              input bit w, input bit t);
    vec_t v;
    v.en = e; v.ld = l; v.up = u; v.sat = s;
    v.mx = 8'(m); v.ci = 8'(c); v.cnt = 8'(q);
    v.wrap = w; v.tc = t;
    tbl.push_back(v);
  endfunction

  initial begin
    res = 1'b0;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]  = 0;
      m_wrap[i] = 1'b0;
    end

    // Columns: en ld up sat MAX CNT_In | CNT WRAP after edge, TC before edge.
    add(0,1,1,0,'hFF,'h5A,'h5A,0,0);
    add(0,1,1,0,'h80,'hF0,'h80,0,0);
    add(0,1,1,0,9,0,0,0,0);
    for (int k = 1; k <= 9; k++) add(1,0,1,0,9,0,k,0,0);
    add(1,0,1,0,9,0,0,1,1);
    add(1,0,1,0,9,0,1,0,0);
    add(0,1,0,0,9,2,2,0,0);
    add(1,0,0,0,9,0,1,0,0);
    add(1,0,0,0,9,0,0,0,0);
    add(1,0,0,0,9,0,9,1,1);
    add(1,0,0,0,9,0,8,0,0);
    add(0,1,0,1,9,2,2,0,0);
    add(1,0,0,1,9,0,1,0,0);
    add(1,0,0,1,9,0,0,0,0);
    add(1,0,0,1,9,0,0,0,1);
    add(1,0,0,1,9,0,0,0,1);
    add(0,1,1,0,9,3,3,0,0);
    add(1,1,1,0,9,7,7,0,0);
    for (int k = 0; k < 4; k++) add(0,0,1,0,9,0,7,0,0);
    add(0,1,1,1,9,9,9,0,0);
    add(1,0,1,1,9,0,9,0,1);
    add(0,1,1,0,'hFF,'hFF,'hFF,0,0);
    add(1,0,1,0,'hFF,0,0,1,1);
    add(0,1,1,0,0,'h33,0,0,0);
    add(1,0,1,0,0,0,0,1,1);
    add(1,0,1,0,0,0,0,1,1);
    add(1,0,0,0,0,0,0,1,1);
    add(1,0,1,1,0,0,0,0,1);
    add(0,1,1,0,20,12,12,0,0);
    add(1,0,1,0,5,0,0,1,1);
    add(0,1,1,0,20,12,12,0,0);
    add(1,0,0,0,5,0,5,0,0);

    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset.cnt.w%0d", W[i]), d_cnt(i), 64'd0);
      chk($sformatf("reset.wrap.w%0d", W[i]), d_wrap(i), 64'd0);
    end
    @(negedge clk);
    res = 1'b1;

    foreach (tbl[k]) begin
      set_in(tbl[k].en, tbl[k].ld, tbl[k].up, tbl[k].sat, 32'(tbl[k].mx), 32'(tbl[k].ci));
      #1;
      chk($sformatf("tbl%0d.tc", k), 64'(if8.TC), 64'(tbl[k].tc));
      apply($sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d.cnt", k), 64'(if8.CNT), 64'(tbl[k].cnt));
      chk($sformatf("tbl%0d.wrap", k), 64'(if8.WRAP), 64'(tbl[k].wrap));
    end

    set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'hFF, 32'h37);
    apply("ld37");
    chk("ld37.cnt8", 64'(if8.CNT), 64'h37);
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'hFF, 32'h0);
    do_reset("rst1");
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'hFF, 32'h0);
    apply("post_rst");
    chk("post_rst.cnt8", 64'(if8.CNT), 64'd1);

    set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF, 32'hFFFF);
    apply("ldtop");
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF, 32'h0);
    apply("wrap_pend");
    chk("wrap_pend.wrap8", 64'(if8.WRAP), 64'd1);
    do_reset("rst2");

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] m_new;
      m_new = mx;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       m_new = 32'd0;
          1:       m_new = 32'($urandom_range(1, 15));
          2:       m_new = 32'hFFFF_FFFF;
          default: m_new = $urandom;
        endcase
      end
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), m_new, $urandom);
      apply("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_n_ud.md
# count_n_ud

Parametrised synchronous up/down counter: WIDTH-bit successor to the fixed 8-bit loadable up-counter. Adds run-time direction, a programmable modulus (MAX), a wrap/saturate mode, a combinational terminal-count flag and a registered wrap pulse. It is the general counter primitive for the memory-unit datapath: address sequencers, loop counters and timeout counters.

## Interface
- WIDTH, 8, counter width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- res  input  1  asynchronous, active-low reset.
- EN  input  1  count enable; ignored while load=1.
- load  input  1  synchronous parallel load; has priority over EN.
- up  input  1  direction: 1 = increment, 0 = decrement.
- sat  input  1  boundary mode: 1 = saturate (hold at bound), 0 = wrap.
- MAX  input  WIDTH  inclusive upper bound; counter range is 0..MAX.
- CNT_In  input  WIDTH  parallel load value.
- CNT  output  WIDTH  registered count.
- TC  output  1  combinational terminal count: the next enabled step hits the boundary.
- WRAP  output  1  registered one-cycle pulse, asserted the cycle after a wrap occurred.

## Operation
- Reset (res=0, any time, asynchronous): CNT=0, WRAP=0. On release, the first rising edge with res=1 evaluates normally.
- Per rising edge, in priority order:
  - load=1: CNT <= min(CNT_In, MAX), clamped unsigned; WRAP <= 0.
  - load=0, EN=0: CNT holds; WRAP <= 0.
  - load=0, EN=1, up=1:
    - CNT < MAX: CNT <= CNT+1, WRAP <= 0.
    - CNT >= MAX, sat=1: CNT <= MAX, WRAP <= 0.
    - CNT >= MAX, sat=0: CNT <= 0, WRAP <= 1.
  - load=0, EN=1, up=0:
    - CNT > MAX (MAX lowered at run time): CNT <= MAX, WRAP <= 0.
    - 0 < CNT <= MAX: CNT <= CNT-1, WRAP <= 0.
    - CNT = 0, sat=1: hold 0, WRAP <= 0.
    - CNT = 0, sat=0: CNT <= MAX, WRAP <= 1.
- TC = EN & ~load & ((up & CNT >= MAX) | (~up & CNT == 0)). TC is independent of sat. Chained counters use TC as the next stage's EN.
- Arithmetic: all comparisons are unsigned, WIDTH bits. No step may overflow past MAX. With MAX = 2^WIDTH-1, the counter behaves as a plain modulo-2^WIDTH counter.
- MAX = 0: CNT stays 0. With EN=1, up or down, and sat=0, WRAP pulses every cycle. TC=1 whenever EN=1 and load=0.
- Direction or mode change: takes effect on the same edge it is sampled. There is no pipeline state.

## Timing
- CNT latency: one clock from sampled inputs to the updated value. Load-to-CNT is one clock.
- TC is purely combinational from CNT, MAX, EN, load and up. It is valid in the same cycle, before the edge that performs the wrap or saturation.
- WRAP is high for exactly one cycle, the cycle after the wrapping edge. It stays high on consecutive cycles only when consecutive edges each wrap (MAX=0 case).
- Reset asserted mid-count forces CNT=0 and WRAP=0 immediately, without waiting for clk. A pending WRAP is discarded.
- Inputs must be stable around the rising edge of clk. There are no multicycle paths.

## Test plan
- Reset/load: with res=0, CNT=0 and WRAP=0. Release reset; load=1, CNT_In=0x5A, MAX=0xFF → after 1 edge CNT=0x5A. Next, load=1, CNT_In=0xF0, MAX=0x80 → CNT=0x80 (clamped).
- Modulo-10 up wrap: MAX=9, sat=0, up=1, EN=1 from CNT=0 → sequence 1..9, then 0. TC=1 while CNT=9. WRAP=1 only in the cycle CNT first shows 0.
- Down wrap and saturate: MAX=9, up=0, CNT=2, sat=0 → 1, 0, 9 with WRAP on the 9 cycle. Repeat with sat=1 → 1, 0, 0, 0; WRAP stays 0 and TC=1 at 0.
- Priority and hold: CNT=3, EN=1, load=1, CNT_In=7 → CNT=7 and TC=0. Then EN=0 for 4 edges → CNT stays 7, WRAP=0.
- Boundary edges: WIDTH=8, MAX=0xFF, CNT=0xFF, up=1 → CNT=0x00 with WRAP. MAX=0 → CNT stays 0 and WRAP is high every cycle. Lower MAX from 20 to 5 while CNT=12 → up gives 0 with WRAP; down gives 5 with no WRAP.
- Async reset mid-count: assert res=0 between clock edges while CNT=0x37 → CNT=0 at once. Release, EN=1, up=1 → first edge gives 1. Also rerun the modulo-10 scenario at WIDTH=4 and WIDTH=16.
